// File: rtl/me_result_fifo.sv
// Result queue between motion-estimation control and mode decision.
// Captures {mv, sad, mb_idx, skip} per finished search; first-word-fall-through output.
module me_result_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MB_IDX_W  = 12,
  parameter int unsigned SKIP_THR  = 256,
  parameter int unsigned MV_CENTER = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       done,
  input  logic [5:0]                 mv_x,
  input  logic [5:0]                 mv_y,
  input  logic [15:0]                min_sad,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [5:0]                 out_mv_x,
  output logic [5:0]                 out_mv_y,
  output logic [15:0]                out_sad,
  output logic [MB_IDX_W-1:0]        out_mb_idx,
  output logic                       out_skip,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [16:0]     SkipThr  = 17'(SKIP_THR);
  localparam logic [5:0]      MvCenter = 6'(MV_CENTER);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [5:0]          mv_x;
    logic [5:0]          mv_y;
    logic [15:0]         sad;
    logic [MB_IDX_W-1:0] mb_idx;
    logic                skip;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [MB_IDX_W-1:0] mb_idx_q, mb_idx_d;
  logic                overflow_q, overflow_d;

  logic   push, pop, wr_en;
  entry_t new_entry, head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = done && (!full || pop);
  assign wr_en     = push && !clear;

  always_comb begin
    new_entry        = '0;
    new_entry.mv_x   = mv_x;
    new_entry.mv_y   = mv_y;
    new_entry.sad    = min_sad;
    new_entry.mb_idx = mb_idx_q;
    new_entry.skip   = ({1'b0, min_sad} < SkipThr) && (mv_x == MvCenter) && (mv_y == MvCenter);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mb_idx_d   = mb_idx_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      mb_idx_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        mb_idx_d = mb_idx_q + MB_IDX_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      // A done that found no room is lost; remember it until cleared.
      if (done && !push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mb_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mb_idx_q   <= mb_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: it is only observed through out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_mv_x   = '0;
    out_mv_y   = '0;
    out_sad    = '0;
    out_mb_idx = '0;
    out_skip   = 1'b0;
    if (out_valid) begin
      out_mv_x   = head.mv_x;
      out_mv_y   = head.mv_y;
      out_sad    = head.sad;
      out_mb_idx = head.mb_idx;
      out_skip   = head.skip;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_me_result_fifo.sv
// Bench for me_result_fifo: directed table, reset/wrap sequences, and random traffic
// checked against a queue-based reference model.
module tb_me_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, done, out_ready;
  logic [5:0]  mv_x, mv_y;
  logic [15:0] min_sad;
  logic        out_valid, out_skip, full, empty, overflow;
  logic [5:0]  out_mv_x, out_mv_y;
  logic [15:0] out_sad;
  logic [11:0] out_mb_idx;
  logic [2:0]  count;

  logic        d2_clear, d2_done, d2_ready;
  logic        d2_valid, d2_skip, d2_full, d2_empty, d2_ovf;
  logic [5:0]  d2_mv_x, d2_mv_y;
  logic [15:0] d2_sad;
  logic [1:0]  d2_idx;
  logic [2:0]  d2_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  me_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .done(done), .mv_x(mv_x), .mv_y(mv_y),
    .min_sad(min_sad), .out_ready(out_ready), .out_valid(out_valid), .out_mv_x(out_mv_x),
    .out_mv_y(out_mv_y), .out_sad(out_sad), .out_mb_idx(out_mb_idx), .out_skip(out_skip),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  me_result_fifo #(.MB_IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(d2_clear), .done(d2_done), .mv_x(6'd1), .mv_y(6'd2),
    .min_sad(16'd3), .out_ready(d2_ready), .out_valid(d2_valid), .out_mv_x(d2_mv_x),
    .out_mv_y(d2_mv_y), .out_sad(d2_sad), .out_mb_idx(d2_idx), .out_skip(d2_skip),
    .count(d2_count), .full(d2_full), .empty(d2_empty), .overflow(d2_ovf)
  );

  // Reference model: an ordered list of stored results plus index counter and sticky flag.
  typedef struct {
    logic [5:0]  mx;
    logic [5:0]  my;
    logic [15:0] sad;
    logic [11:0] idx;
    logic        skip;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_mb;
  bit          m_ovf;

  task automatic model_reset();
    mq.delete();
    m_mb  = 0;
    m_ovf = 0;
  endtask

  task automatic model_update();
    bit   do_pop, do_push;
    ent_t e;
    if (clear) begin
      model_reset();
    end else begin
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = done && ((mq.size() < 4) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.mx   = mv_x;
        e.my   = mv_y;
        e.sad  = min_sad;
        e.idx  = 12'(m_mb);
        e.skip = (min_sad < 256) && (mv_x == 16) && (mv_y == 16);
        mq.push_back(e);
        m_mb = (m_mb + 1) % 4096;
      end
      if (done && !do_push) m_ovf = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    h = '{default: '0};
    if (mq.size() > 0) h = mq[0];
    chk({tag, " valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, " mv_x"},  32'(out_mv_x),  32'(h.mx));
    chk({tag, " mv_y"},  32'(out_mv_y),  32'(h.my));
    chk({tag, " sad"},   32'(out_sad),   32'(h.sad));
    chk({tag, " idx"},   32'(out_mb_idx), 32'(h.idx));
    chk({tag, " skip"},  32'(out_skip),  32'(h.skip));
    chk({tag, " count"}, 32'(count),     32'(mq.size()));
    chk({tag, " full"},  32'(full),      32'(mq.size() == 4));
    chk({tag, " empty"}, 32'(empty),     32'(mq.size() == 0));
    chk({tag, " ovf"},   32'(overflow),  32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        clr, dn, rdy;
    logic [5:0]  mx, my;
    logic [15:0] sad;
    logic        e_valid;
    logic [15:0] e_sad;
    logic [11:0] e_idx;
    logic        e_skip;
    logic [2:0]  e_cnt;
    logic        e_full, e_ovf;
  } vec_t;

  vec_t vecs[18];

  task automatic setv(input int i, input logic clr, input logic dn, input logic rdy,
                      input logic [5:0] mx, input logic [5:0] my, input logic [15:0] sad,
                      input logic ev, input logic [15:0] es, input logic [11:0] ei,
                      input logic ek, input logic [2:0] ec, input logic ef, input logic eo);
    vecs[i].clr = clr; vecs[i].dn = dn; vecs[i].rdy = rdy;
    vecs[i].mx = mx; vecs[i].my = my; vecs[i].sad = sad;
    vecs[i].e_valid = ev; vecs[i].e_sad = es; vecs[i].e_idx = ei; vecs[i].e_skip = ek;
    vecs[i].e_cnt = ec; vecs[i].e_full = ef; vecs[i].e_ovf = eo;
  endtask

  int exp_idx2[5] = '{0, 1, 2, 3, 0};

  initial begin
    //      clr dn rdy mx  my  sad   valid sad  idx skip cnt full ovf
    setv(0,  0, 1, 0, 16, 16, 100,  1, 100,  0, 1, 1, 0, 0);
    setv(1,  0, 0, 1,  0,  0,   0,  0,   0,  0, 0, 0, 0, 0);
    setv(2,  1, 0, 0,  0,  0,   0,  0,   0,  0, 0, 0, 0, 0);
    setv(3,  0, 1, 0,  3,  5,  10,  1,  10,  0, 0, 1, 0, 0);
    setv(4,  0, 1, 0,  3,  5,  20,  1,  10,  0, 0, 2, 0, 0);
    setv(5,  0, 1, 0,  3,  5,  30,  1,  10,  0, 0, 3, 0, 0);
    setv(6,  0, 1, 0,  3,  5,  40,  1,  10,  0, 0, 4, 1, 0);
    setv(7,  0, 1, 0,  3,  5,  50,  1,  10,  0, 0, 4, 1, 1);
    setv(8,  0, 1, 1, 16, 16, 500,  1,  20,  1, 0, 4, 1, 1);
    setv(9,  0, 0, 1,  0,  0,   0,  1,  30,  2, 0, 3, 0, 1);
    setv(10, 0, 0, 1,  0,  0,   0,  1,  40,  3, 0, 2, 0, 1);
    setv(11, 0, 0, 1,  0,  0,   0,  1, 500,  4, 0, 1, 0, 1);
    setv(12, 0, 0, 1,  0,  0,   0,  0,   0,  0, 0, 0, 0, 1);
    setv(13, 0, 1, 0,  3,  5,   1,  1,   1,  5, 0, 1, 0, 1);
    setv(14, 0, 1, 0,  3,  5,   2,  1,   1,  5, 0, 2, 0, 1);
    setv(15, 1, 1, 1, 16, 16,   5,  0,   0,  0, 0, 0, 0, 0);
    setv(16, 0, 1, 0, 16, 16, 255,  1, 255,  0, 1, 1, 0, 0);
    setv(17, 0, 0, 1,  0,  0,   0,  0,   0,  0, 0, 0, 0, 0);

    rst_n = 1'b0; clear = 0; done = 0; out_ready = 0; mv_x = 0; mv_y = 0; min_sad = 0;
    d2_clear = 0; d2_done = 0; d2_ready = 0;
    model_reset();
    #2;
    check_model("in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_model("post_reset");

    for (int i = 0; i < 18; i++) begin
      clear = vecs[i].clr; done = vecs[i].dn; out_ready = vecs[i].rdy;
      mv_x = vecs[i].mx; mv_y = vecs[i].my; min_sad = vecs[i].sad;
      step();
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d sad", i),   32'(out_sad),   32'(vecs[i].e_sad));
      chk($sformatf("vec%0d idx", i),   32'(out_mb_idx), 32'(vecs[i].e_idx));
      chk($sformatf("vec%0d skip", i),  32'(out_skip),  32'(vecs[i].e_skip));
      chk($sformatf("vec%0d count", i), 32'(count),     32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d full", i),  32'(full),      32'(vecs[i].e_full));
      chk($sformatf("vec%0d ovf", i),   32'(overflow),  32'(vecs[i].e_ovf));
    end
    clear = 0; out_ready = 0;

    // Fill to three entries, then reset between edges.
    for (int i = 0; i < 3; i++) begin
      done = 1; mv_x = 3; mv_y = 5; min_sad = 16'(7 + i);
      step();
    end
    chk("pre_rst count", 32'(count), 32'd3);
    done = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async valid", 32'(out_valid), 32'd0);
    chk("rst_async empty", 32'(empty), 32'd1);
    chk("rst_async count", 32'(count), 32'd0);
    chk("rst_async sad",   32'(out_sad), 32'd0);
    #1 rst_n = 1'b1;
    done = 1; mv_x = 16; mv_y = 16; min_sad = 256;
    step();
    chk("rst_rel valid", 32'(out_valid), 32'd1);
    chk("rst_rel skip",  32'(out_skip), 32'd0);
    chk("rst_rel idx",   32'(out_mb_idx), 32'd0);
    check_model("rst_rel");

    for (int n = 0; n < 500; n++) begin
      done      = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      clear     = ($urandom_range(0, 99) == 0);
      mv_x      = ($urandom_range(0, 3) == 0) ? 6'd16 : 6'($urandom);
      mv_y      = ($urandom_range(0, 3) != 3) ? 6'd16 : 6'($urandom);
      case ($urandom_range(0, 2))
        0:       min_sad = 16'($urandom_range(250, 262));
        1:       min_sad = 16'($urandom);
        default: min_sad = 16'($urandom_range(0, 50));
      endcase
      step();
      check_model($sformatf("rnd%0d", n));
    end
    done = 0; clear = 0; out_ready = 0;

    // Narrow index counter wraps 3 -> 0 under continuous push and pop.
    for (int i = 0; i < 5; i++) begin
      d2_done = 1; d2_ready = 1;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d valid", i), 32'(d2_valid), 32'd1);
      chk($sformatf("wrap%0d idx", i), 32'(d2_idx), 32'(exp_idx2[i]));
    end
    d2_done = 0;
    @(posedge clk); #1;
    chk("wrap empty", 32'(d2_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
